// File: rtl/write_buffer_pkg.sv
// Shared types for the posted-write buffer: FIFO entry layout,
// requester/drain state encodings and the default FIFO depth.
package write_buffer_pkg;

    localparam int WB_DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        WAIT_DRAIN,
        READ,
        DONE
    } req_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FETCH,
        D_WRITE
    } drn_state_e;

endpackage

// File: rtl/write_buffer_bram.sv
// bram_dual: simple dual-port RAM, port A write, port B registered read.
// Ports: i_clock, i_a_we/i_a_addr/i_a_data, i_b_re/i_b_addr, o_b_data.
// Read-during-write on the same address returns the old contents.
module bram_dual #(
    parameter int WIDTH = 64,
    parameter int SIZE  = 16,
    localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             i_clock,
    input  logic             i_a_we,
    input  logic [AW-1:0]    i_a_addr,
    input  logic [WIDTH-1:0] i_a_data,
    input  logic             i_b_re,
    input  logic [AW-1:0]    i_b_addr,
    output logic [WIDTH-1:0] o_b_data
);

    logic [WIDTH-1:0] mem_q [SIZE];

    always_ff @(posedge i_clock) begin
        if (i_a_we) begin
            mem_q[i_a_addr] <= i_a_data;
        end
        if (i_b_re) begin
            o_b_data <= mem_q[i_b_addr];
        end
    end

endmodule

// File: rtl/write_buffer.sv
// write_buffer: posted writes queued and drained to a 32-bit bus in order;
// reads wait for the queue to empty, then pass through to the bus.
// Ports: i_clock/i_reset (async, active-low), requester i_request/i_rw/
// i_address/i_wdata -> o_ready/o_rdata, bus o_bus_* / i_bus_rdata/i_bus_ready.
// Macro WRITE_BUFFER_EN enables the FIFO; undefined, writes pass through.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEFAULT_DEPTH
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready
);

    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("write_buffer: DEPTH must be a power of two in 2..256");
    end

    req_state_e  req_q, req_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_rw_q, bus_rw_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_done;
    logic        rd_go;
    logic        rd_clear;

    assign bus_done = bus_req_q && i_bus_ready;

`ifdef WRITE_BUFFER_EN
    localparam int AW = $clog2(DEPTH);

    drn_state_e drn_q, drn_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count;
    logic        full, empty;
    logic        push, pop, fetch, load;
    wb_entry_t   head, push_entry;

    assign count      = wptr_q - rptr_q;
    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign rd_clear   = empty && (drn_q == D_IDLE);
    assign push_entry = '{addr: i_address, data: i_wdata};

    bram_dual #(
        .WIDTH (64),
        .SIZE  (DEPTH)
    ) u_ram (
        .i_clock  (i_clock),
        .i_a_we   (push),
        .i_a_addr (wptr_q[AW-1:0]),
        .i_a_data (push_entry),
        .i_b_re   (fetch),
        .i_b_addr (rptr_q[AW-1:0]),
        .o_b_data (head)
    );

    // Head entry stays in the FIFO until its bus write completes.
    always_comb begin
        drn_d = drn_q;
        fetch = 1'b0;
        load  = 1'b0;
        pop   = 1'b0;
        unique case (drn_q)
            D_IDLE: begin
                if (!empty && (req_q != READ)) begin
                    fetch = 1'b1;
                    drn_d = D_FETCH;
                end
            end
            D_FETCH: begin
                load  = 1'b1;
                drn_d = D_WRITE;
            end
            D_WRITE: begin
                if (bus_done) begin
                    pop   = 1'b1;
                    drn_d = D_IDLE;
                end
            end
            default: drn_d = D_IDLE;
        endcase
    end

    assign wptr_d = wptr_q + (AW+1)'(push);
    assign rptr_d = rptr_q + (AW+1)'(pop);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            drn_q  <= D_IDLE;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            drn_q  <= drn_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
`else
    assign rd_clear = 1'b1;
`endif

    // A pop in the same cycle frees a slot for this cycle's push.
    always_comb begin
        req_d   = req_q;
        ready_d = 1'b0;
        rd_go   = 1'b0;
`ifdef WRITE_BUFFER_EN
        push    = 1'b0;
`endif
        unique case (req_q)
            IDLE: begin
                if (i_request) begin
`ifdef WRITE_BUFFER_EN
                    if (!i_rw) begin
                        req_d = WAIT_DRAIN;
                    end else if (!full || pop) begin
                        push    = 1'b1;
                        ready_d = 1'b1;
                        req_d   = DONE;
                    end else begin
                        req_d = WAIT_SLOT;
                    end
`else
                    req_d = WAIT_DRAIN;
`endif
                end
            end
            WAIT_SLOT: begin
`ifdef WRITE_BUFFER_EN
                if (!full || pop) begin
                    push    = 1'b1;
                    ready_d = 1'b1;
                    req_d   = DONE;
                end
`else
                req_d = IDLE;
`endif
            end
            WAIT_DRAIN: begin
                if (rd_clear) begin
                    rd_go = 1'b1;
                    req_d = READ;
                end
            end
            READ: begin
                if (bus_done) begin
                    ready_d = 1'b1;
                    req_d   = DONE;
                end
            end
            DONE: begin
                if (!i_request) begin
                    req_d = IDLE;
                end
            end
            default: req_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_d   = bus_req_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        if (bus_done) begin
            bus_req_d = 1'b0;
        end
        if ((req_q == READ) && bus_done && !bus_rw_q) begin
            rdata_d = i_bus_rdata;
        end
        if (rd_go) begin
            bus_req_d  = 1'b1;
            bus_addr_d = i_address;
`ifdef WRITE_BUFFER_EN
            bus_rw_d    = 1'b0;
`else
            bus_rw_d    = i_rw;
            bus_wdata_d = i_wdata;
`endif
        end
`ifdef WRITE_BUFFER_EN
        if (load) begin
            bus_req_d   = 1'b1;
            bus_rw_d    = 1'b1;
            bus_addr_d  = head.addr;
            bus_wdata_d = head.data;
        end
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            req_q       <= IDLE;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            req_q       <= req_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_rdata       = rdata_q;
    assign o_bus_request = bus_req_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_write_buffer.sv
// Testbench for write_buffer: random requester traffic against a
// memory/scoreboard model, plus directed ordering, stall and reset cases.
module tb_write_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_request = 1'b0;
    logic        i_rw = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_ready = 1'b0;

    always #5 clk = ~clk;

    write_buffer #(.DEPTH(DEPTH)) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          rw;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        rsp_t;
    logic [31:0] busmem [logic [31:0]];
    logic [31:0] refmem [logic [31:0]];
    bit          stall = 1'b0;
    int          wait_cnt = 3;
    int          ready_cyc = -10;
    int          bus_wr_done = 0;
    int          acked = 0;
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Bus slave: random latency, own memory, checks bus order vs scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (i_bus_ready) begin
                i_bus_ready = 1'b0;
                chk("bus_req_fall", o_bus_request, 0);
            end else if (rst_n && o_bus_request && !stall) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    i_bus_ready = 1'b1;
                    ready_cyc = cyc;
                    wait_cnt = $urandom_range(0, 3);
                    if (exp_q.size() == 0) begin
                        chk("bus_extra", 1, 0);
                    end else begin
                        rsp_t = exp_q.pop_front();
                        chk("bus_rw", o_bus_rw, rsp_t.rw);
                        chk("bus_addr", o_bus_address, rsp_t.a);
                        if (rsp_t.rw) chk("bus_wdata", o_bus_wdata, rsp_t.d);
                    end
                    if (o_bus_rw) begin
                        busmem[o_bus_address] = o_bus_wdata;
                        bus_wr_done++;
                    end else begin
                        i_bus_rdata = busmem.exists(o_bus_address) ?
                            busmem[o_bus_address] : init_val(o_bus_address);
                    end
                end
            end
        end
    end

    task automatic xact(input bit rw, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
        txn_t        e;
        int          t0;
        int          outst;
        bit          got;
        logic [31:0] expd;
        outst = acked - bus_wr_done;
        e.rw = rw;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        if (rw) refmem[a] = d;
        i_request = 1'b1;
        i_rw = rw;
        i_address = a;
        i_wdata = d;
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
        end
        if (!got) begin
            chk("timeout", 0, 1);
        end else begin
`ifdef WRITE_BUFFER_EN
            if (rw && outst < DEPTH) chk("wr_lat", cyc - t0, 1);
            else chk("rdy_lat", cyc, ready_cyc + 1);
`else
            chk("rdy_lat", cyc, ready_cyc + 1);
`endif
            if (rw) begin
                chk("rdata_hold", o_rdata, last_rd);
                acked++;
            end else begin
                expd = refmem.exists(a) ? refmem[a] : init_val(a);
                chk("rdata", o_rdata, expd);
                last_rd = expd;
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("ready_pulse", o_ready, 0);
        end
        i_request = 1'b0;
        @(negedge clk);
    endtask

    int busy;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_busreq", o_bus_request, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_busaddr", o_bus_address, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xact(1'b1, 32'h100, 32'hDEADBEEF, 0);
        xact(1'b1, 32'h200, 32'h11111111, 2);
        xact(1'b0, 32'h200, 32'h0, 0);
        xact(1'b0, 32'h300, 32'h0, 5);

`ifdef WRITE_BUFFER_EN
        stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            xact(1'b1, 32'h2000 + 32'(i * 4), $urandom, 0);
        end
        fork
            xact(1'b1, 32'h2040, $urandom, 0);
            begin
                repeat (6) @(negedge clk);
                stall = 1'b0;
            end
        join
        for (int i = 17; i < 20; i++) begin
            xact(1'b1, 32'h2000 + 32'(i * 4), $urandom, 0);
        end
`endif

        for (int i = 0; i < 150; i++) begin
            xact(1'($urandom_range(0, 1)),
                 32'h1000 + 32'($urandom_range(0, 15) << 2),
                 $urandom, $urandom_range(0, 5));
        end

        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drained", exp_q.size(), 0);

        stall = 1'b1;
`ifdef WRITE_BUFFER_EN
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 32'h3000 + 32'(i * 4), $urandom, 0);
        end
`else
        i_request = 1'b1;
        i_rw = 1'b1;
        i_address = 32'h3000;
        i_wdata = 32'hCAFEF00D;
`endif
        for (int k = 0; k < 50 && !o_bus_request; k++) @(negedge clk);
        chk("pre_rst_busreq", o_bus_request, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busreq", o_bus_request, 0);
        chk("arst_busrw", o_bus_rw, 0);
        chk("arst_busaddr", o_bus_address, 0);
        chk("arst_buswdata", o_bus_wdata, 0);
        chk("arst_ready", o_ready, 0);
        chk("arst_rdata", o_rdata, 0);
        i_request = 1'b0;
        exp_q.delete();
        acked = bus_wr_done;
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_bus_request) busy++;
        end
        chk("post_rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
